// File: rtl/prv_trap_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prv_trap_ctrl_if : trap flags, CSR inputs and redirect outputs   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface prv_trap_ctrl_if;
  logic        fault_insn;
  logic        mal_insn;
  logic        illegal_insn;
  logic        fault_l;
  logic        mal_l;
  logic        fault_s;
  logic        mal_s;
  logic        breakpoint;
  logic        env;
  logic        ret;
  logic        timer_int;
  logic        soft_int;
  logic        ext_int;
  logic        mie_global;
  logic [31:0] epc;
  logic [31:0] badaddr;
  logic        pipe_clear;
  logic [31:0] mtvec;
  logic [31:0] mepc_r;
  logic [31:0] priv_pc;
  logic        insert_pc;
  logic        intr;
  logic        trap_we;
  logic [31:0] mcause;
  logic [31:0] mepc;
  logic [31:0] mtval;

  // master is the hazard/CSR side, slave is the trap controller
  modport master (
    output fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
           breakpoint, env, ret, timer_int, soft_int, ext_int, mie_global,
           epc, badaddr, pipe_clear, mtvec, mepc_r,
    input  priv_pc, insert_pc, intr, trap_we, mcause, mepc, mtval
  );

  modport slave (
    input  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
           breakpoint, env, ret, timer_int, soft_int, ext_int, mie_global,
           epc, badaddr, pipe_clear, mtvec, mepc_r,
    output priv_pc, insert_pc, intr, trap_we, mcause, mepc, mtval
  );
endinterface
`default_nettype wire

// File: rtl/prv_trap_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prv_trap_ctrl : machine-mode trap entry and MRET redirect FSM    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module prv_trap_ctrl #(
  parameter int unsigned VECTORED_EN = 1
) (
  input  logic           clk,
  input  logic           rst,
  prv_trap_ctrl_if.slave bus
);
  localparam bit c_VECTORED = (VECTORED_EN != 0);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_CLEAR = 2'd1,
    S_REDIRECT   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_exc;
  logic        w_int_ok;
  logic        w_take;
  logic [3:0]  w_code;
  logic [31:0] w_tval;
  logic [31:0] w_base;
  logic [31:0] w_target;
  logic        w_trap_we;
  logic        w_insert_pc;
  logic        w_intr;
  logic        r_is_trap;
  logic [31:0] r_target;
  logic [31:0] r_mcause;
  logic [31:0] r_mepc;
  logic [31:0] r_mtval;

  // Cause selection: exceptions first, then interrupts, each in priority order
  always_comb begin
    w_exc    = bus.breakpoint | bus.fault_insn | bus.mal_insn | bus.illegal_insn |
               bus.mal_l | bus.mal_s | bus.fault_l | bus.fault_s | bus.env;
    w_int_ok = bus.mie_global & ~w_exc & (bus.ext_int | bus.soft_int | bus.timer_int);
    w_take   = w_exc | w_int_ok;
    w_code   = 4'd0;
    w_tval   = 32'd0;
    if (bus.breakpoint) begin
      w_code = 4'd3;
      w_tval = bus.epc;
    end else if (bus.fault_insn) begin
      w_code = 4'd1;
      w_tval = bus.badaddr;
    end else if (bus.mal_insn) begin
      w_code = 4'd0;
      w_tval = bus.badaddr;
    end else if (bus.illegal_insn) begin
      w_code = 4'd2;
    end else if (bus.mal_l) begin
      w_code = 4'd4;
      w_tval = bus.badaddr;
    end else if (bus.mal_s) begin
      w_code = 4'd6;
      w_tval = bus.badaddr;
    end else if (bus.fault_l) begin
      w_code = 4'd5;
      w_tval = bus.badaddr;
    end else if (bus.fault_s) begin
      w_code = 4'd7;
      w_tval = bus.badaddr;
    end else if (bus.env) begin
      w_code = 4'd11;
    end else if (bus.ext_int) begin
      w_code = 4'd11;
    end else if (bus.soft_int) begin
      w_code = 4'd3;
    end else if (bus.timer_int) begin
      w_code = 4'd7;
    end
    w_base   = {bus.mtvec[31:2], 2'b00};
    w_target = (c_VECTORED && (bus.mtvec[1:0] == 2'b01) && w_int_ok)
             ? (w_base + {26'd0, w_code, 2'b00}) : w_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_trap_we   = 1'b0;
    w_insert_pc = 1'b0;
    w_intr      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_trap_we = 1'b1;
          w_next    = S_WAIT_CLEAR;
        end else if (bus.ret) begin
          w_next = S_WAIT_CLEAR;
        end
      end
      S_WAIT_CLEAR: begin
        w_intr = r_is_trap;
        if (bus.pipe_clear) begin
          w_next = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        w_intr      = r_is_trap;
        w_insert_pc = 1'b1;
        w_next      = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_trap <= 1'b0;
      r_target  <= 32'd0;
      r_mcause  <= 32'd0;
      r_mepc    <= 32'd0;
      r_mtval   <= 32'd0;
    end else if (w_trap_we) begin
      r_is_trap <= 1'b1;
      r_target  <= w_target;
      r_mcause  <= {w_int_ok, 27'd0, w_code};
      r_mepc    <= bus.epc;
      r_mtval   <= w_tval;
    end else if ((r_state == S_IDLE) && bus.ret) begin
      r_is_trap <= 1'b0;
      r_target  <= bus.mepc_r;
    end
  end

  // A sampled reset must not leak a CSR write strobe from active inputs
  assign bus.trap_we   = w_trap_we & ~rst;
  assign bus.insert_pc = w_insert_pc;
  assign bus.intr      = w_intr;
  assign bus.priv_pc   = r_target;
  assign bus.mcause    = r_mcause;
  assign bus.mepc      = r_mepc;
  assign bus.mtval     = r_mtval;
endmodule
`default_nettype wire
